// File: rtl/quad_input_filter.sv
// Quadrature input conditioner: per-channel synchroniser, stability filter,
// Gray-code step/illegal-transition detection and saturating error/glitch counters.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [FILT_W-1:0] filt_cycles,
  input  logic              err_clr,
  input  logic              enc_a_raw,
  input  logic              enc_b_raw,
  output logic              enc_a,
  output logic              enc_b,
  output logic              step_valid,
  output logic              illegal_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  glitch_cnt
);

  localparam int CHAIN  = SYNC_STAGES + 1;
  localparam int INIT_W = $clog2(CHAIN + 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  typedef struct packed {
    logic              out;
    logic [FILT_W-1:0] cnt;
    logic              upd;
    logic              rej;
  } filt_t;

  function automatic filt_t filt_step(input logic s, input logic out,
                                      input logic [FILT_W-1:0] cnt,
                                      input logic [FILT_W-1:0] n);
    filt_t r;
    r.out = out;
    r.cnt = cnt;
    r.upd = 1'b0;
    r.rej = 1'b0;
    if (s != out) begin
      if (cnt >= n) begin
        r.out = s;
        r.cnt = '0;
        r.upd = 1'b1;
      end else begin
        r.cnt = cnt + FILT_W'(1);
      end
    end else if (cnt != '0) begin
      r.cnt = '0;
      r.rej = 1'b1;
    end else begin
      r.rej = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, v} + (CNT_W+1)'(inc);
    if (sum[CNT_W]) begin
      return '1;
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  state_t             state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [CHAIN-1:0]   a_sync_q, a_sync_d, b_sync_q, b_sync_d;
  logic [FILT_W-1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic               enc_a_q, enc_a_d, enc_b_q, enc_b_d;
  logic               step_valid_q, step_valid_d;
  logic               illegal_err_q, illegal_err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d, glitch_cnt_q, glitch_cnt_d;
  filt_t              fa_s, fb_s;
  logic [1:0]         glitch_inc_s;

  assign fa_s = filt_step(a_sync_q[CHAIN-1], enc_a_q, a_cnt_q, filt_cycles);
  assign fb_s = filt_step(b_sync_q[CHAIN-1], enc_b_q, b_cnt_q, filt_cycles);
  assign glitch_inc_s = {1'b0, fa_s.rej} + {1'b0, fb_s.rej};

  always_comb begin
    a_sync_d      = {a_sync_q[CHAIN-2:0], enc_a_raw};
    b_sync_d      = {b_sync_q[CHAIN-2:0], enc_b_raw};
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    a_cnt_d       = '0;
    b_cnt_d       = '0;
    enc_a_d       = enc_a_q;
    enc_b_d       = enc_b_q;
    step_valid_d  = 1'b0;
    illegal_err_d = err_clr ? 1'b0 : illegal_err_q;
    err_cnt_d     = err_clr ? '0 : err_cnt_q;
    glitch_cnt_d  = err_clr ? '0 : glitch_cnt_q;

    case (state_q)
      ST_INIT: begin
        // Load the value the last sync stage is about to hold so RUN starts with out == s.
        enc_a_d = a_sync_q[CHAIN-2];
        enc_b_d = b_sync_q[CHAIN-2];
        if (init_cnt_q == INIT_W'(CHAIN - 1)) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      ST_RUN: begin
        if (enable) begin
          a_cnt_d      = fa_s.cnt;
          b_cnt_d      = fb_s.cnt;
          enc_a_d      = fa_s.out;
          enc_b_d      = fb_s.out;
          step_valid_d = fa_s.upd ^ fb_s.upd;
          if (fa_s.upd && fb_s.upd) begin
            illegal_err_d = 1'b1;
            err_cnt_d     = sat_add(err_cnt_d, 2'd1);
          end else begin
            illegal_err_d = illegal_err_d;
          end
          glitch_cnt_d = sat_add(glitch_cnt_d, glitch_inc_s);
        end else begin
          step_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      a_sync_q      <= '0;
      b_sync_q      <= '0;
      a_cnt_q       <= '0;
      b_cnt_q       <= '0;
      enc_a_q       <= 1'b0;
      enc_b_q       <= 1'b0;
      step_valid_q  <= 1'b0;
      illegal_err_q <= 1'b0;
      err_cnt_q     <= '0;
      glitch_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      a_sync_q      <= a_sync_d;
      b_sync_q      <= b_sync_d;
      a_cnt_q       <= a_cnt_d;
      b_cnt_q       <= b_cnt_d;
      enc_a_q       <= enc_a_d;
      enc_b_q       <= enc_b_d;
      step_valid_q  <= step_valid_d;
      illegal_err_q <= illegal_err_d;
      err_cnt_q     <= err_cnt_d;
      glitch_cnt_q  <= glitch_cnt_d;
    end
  end

  assign enc_a       = enc_a_q;
  assign enc_b       = enc_b_q;
  assign step_valid  = step_valid_q;
  assign illegal_err = illegal_err_q;
  assign err_cnt     = err_cnt_q;
  assign glitch_cnt  = glitch_cnt_q;

endmodule
